// File: rtl/bcd_counter_mux_pkg.sv
// Shared BCD and seven-segment definitions used by the counter and other display blocks.
// Segment encodings are active-low {dp,g,f,e,d,c,b,a}, with dp always off.
package bcd_counter_mux_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    function automatic logic [7:0] bcd_to_sseg(input bcd_t d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Out-of-range nibbles on load saturate to 9 so the count is always valid BCD.
    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_counter_mux_digit.sv
// One BCD digit of the up/down chain: steps when ci is high and passes co
// to the next digit when it is at its terminal value (9 up, 0 down).
module bcd_digit
    import bcd_counter_mux_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  bcd_t load_val,
    input  logic ci,
    input  logic up,
    output bcd_t q,
    output logic co
);

    bcd_t q_reg;
    bcd_t q_next;
    logic terminal;

    assign terminal = up ? (q_reg == 4'd9) : (q_reg == 4'd0);
    assign co       = terminal & ci;
    assign q        = q_reg;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = bcd_sat(load_val);
        end else if (ci) begin
            if (terminal)
                q_next = up ? 4'd0 : 4'd9;
            else
                q_next = up ? (q_reg + 4'd1) : (q_reg - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_reg <= '0;
        else
            q_reg <= q_next;
    end

endmodule

// File: rtl/bcd_counter_mux.sv
// N-digit BCD up/down counter with prescaler and multiplexed seven-segment driver,
// all in the clk domain with no derived clocks.
module bcd_counter_mux
    import bcd_counter_mux_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE_MAX = 49_999_999,
    parameter int REFRESH_W    = 18,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tick,
    output logic                carry,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          seg
);

    localparam int PW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;

    logic [PW-1:0]        presc_reg, presc_next;
    logic                 tick_reg, tick_next;
    logic                 carry_reg, carry_next;
    logic [REFRESH_W-1:0] refresh_reg;
    logic [DIGITS-1:0]    an_reg, an_next;
    logic [7:0]           seg_reg, seg_next;
    logic                 presc_term;
    logic [DIGITS:0]      ci_chain;
    logic [DIGITS-1:0]    zero_up;
    logic [2:0]           slot_raw, slot_idx;
    bcd_t                 digit_q [DIGITS];

    // Prescaler: the tick is registered, so the count steps one clk after the terminal value.
    assign presc_term = (presc_reg == PW'(PRESCALE_MAX));

    always_comb begin
        presc_next = presc_reg;
        tick_next  = 1'b0;
        if (clr) begin
            presc_next = '0;
        end else if (en) begin
            presc_next = presc_term ? '0 : (presc_reg + PW'(1));
            tick_next  = presc_term;
        end
    end

    assign ci_chain[0] = tick_reg;
    assign carry_next  = ci_chain[DIGITS] & ~clr & ~load;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .reset    (reset),
                .clr      (clr),
                .load     (load),
                .load_val (load_val[4*gi +: 4]),
                .ci       (ci_chain[gi]),
                .up       (up),
                .q        (digit_q[gi]),
                .co       (ci_chain[gi+1])
            );
            assign count[4*gi +: 4] = digit_q[gi];

            // zero_up[k]: digit k and every digit above it are zero.
            if (gi == DIGITS - 1) begin : g_top
                assign zero_up[gi] = (digit_q[gi] == 4'd0);
            end else begin : g_mid
                assign zero_up[gi] = (digit_q[gi] == 4'd0) && zero_up[gi+1];
            end
        end
    endgenerate

    assign slot_raw = refresh_reg[REFRESH_W-1 -: 3];
    assign slot_idx = 3'(int'(slot_raw) % DIGITS);

    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        for (int k = 0; k < DIGITS; k++) begin
            if (slot_idx == 3'(k)) begin
                an_next[k] = 1'b0;
                seg_next   = (BLANK_LZ && (k > 0) && zero_up[k]) ? SEG_BLANK
                                                                 : bcd_to_sseg(digit_q[k]);
            end
        end
    end

    // Anode and segment registers load together so the pins never show a skewed pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg   <= '0;
            tick_reg    <= 1'b0;
            carry_reg   <= 1'b0;
            refresh_reg <= '0;
            an_reg      <= ~DIGITS'(1);
            seg_reg     <= SEG_ZERO;
        end else begin
            presc_reg   <= presc_next;
            tick_reg    <= tick_next;
            carry_reg   <= carry_next;
            refresh_reg <= refresh_reg + REFRESH_W'(1);
            an_reg      <= an_next;
            seg_reg     <= seg_next;
        end
    end

    assign tick  = tick_reg;
    assign carry = carry_reg;
    assign an    = an_reg;
    assign seg   = seg_reg;

endmodule

// File: tb/tb_bcd_counter_mux.sv
// Directed bench for bcd_counter_mux with a short prescaler and fast refresh.
module tb_bcd_counter_mux;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        tick;
    logic        carry;
    logic [3:0]  an;
    logic [7:0]  seg;

    int vec_cnt = 0;
    int err_cnt = 0;

    bcd_counter_mux #(
        .DIGITS       (4),
        .PRESCALE_MAX (3),
        .REFRESH_W    (5),
        .BLANK_LZ     (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .carry    (carry),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("vec %0d %s: %h ok", vec_cnt, tag, got);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 20);
        if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic load_now(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Freeze the count at val and check four full refresh slots of an/seg.
    task automatic check_display(input logic [15:0] val, input logic [7:0] s0,
                                 input logic [7:0] s1, input logic [7:0] s2,
                                 input logic [7:0] s3);
        logic [3:0] an_seq  [4];
        logic [7:0] seg_seq [4];
        logic [3:0] prev_an;
        bit         found;
        int         guard;
        an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_seq = '{s0, s1, s2, s3};
        en = 1'b0;
        load_now(val);
        prev_an = an;
        guard   = 0;
        found   = 1'b0;
        do begin
            @(negedge clk);
            guard++;
            found   = (an == 4'hE) && (prev_an != 4'hE);
            prev_an = an;
        end while (!found && guard < 40);
        if (!found) chk("disp_sync", 32'(an), 32'hE);
        for (int k = 0; k < 16; k++) begin
            chk("disp_an", 32'(an), 32'(an_seq[k/4]));
            chk("disp_seg", 32'(seg), 32'(seg_seq[k/4]));
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        en       = 1'b1;
        up       = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
        repeat (3) @(negedge clk);

        // 1: reset state, then count up 0001..0010 with a tick every 4 clk
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_seg", 32'(seg), 32'hC0);
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wait_tick(n);
            chk("tick_gap", 32'(n), (i == 1) ? 32'd4 : 32'd3);
            @(negedge clk);
            chk("up_count", 32'(count), 32'(((i / 10) << 4) | (i % 10)));
            chk("up_carry", 32'(carry), 32'h0);
            chk("tick_width", 32'(tick), 32'h0);
        end

        // 2: wrap upward from 9998
        load_now(16'h9998);
        wait_tick(n);
        @(negedge clk);
        chk("wrap_up_9999", 32'(count), 32'h9999);
        chk("wrap_up_nocarry", 32'(carry), 32'h0);
        wait_tick(n);
        @(negedge clk);
        chk("wrap_up_count", 32'(count), 32'h0000);
        chk("wrap_up_carry", 32'(carry), 32'h1);
        @(negedge clk);
        chk("wrap_up_carry_off", 32'(carry), 32'h0);

        // 3: wrap downward from 0000, then direction change takes effect at next tick
        up = 1'b0;
        load_now(16'h0000);
        wait_tick(n);
        @(negedge clk);
        chk("wrap_dn_count", 32'(count), 32'h9999);
        chk("wrap_dn_carry", 32'(carry), 32'h1);
        @(negedge clk);
        chk("wrap_dn_carry_off", 32'(carry), 32'h0);
        wait_tick(n);
        @(negedge clk);
        chk("down_9998", 32'(count), 32'h9998);
        up = 1'b1;
        wait_tick(n);
        @(negedge clk);
        chk("dir_change", 32'(count), 32'h9999);

        // 4: load beats a coincident tick, clamps nibbles; clr beats load
        wait_tick(n);
        load_now(16'h0A3F);
        chk("load_clamp", 32'(count), 32'h0939);
        chk("load_nocarry", 32'(carry), 32'h0);
        clr = 1'b1;
        load_now(16'h1234);
        clr = 1'b0;
        chk("clr_over_load", 32'(count), 32'h0000);
        wait_tick(n);
        chk("clr_presc", 32'(n), 32'd4);
        @(negedge clk);
        chk("after_clr", 32'(count), 32'h0001);

        // 5: display multiplexing with leading-zero blanking
        check_display(16'h0042, 8'hA4, 8'h99, 8'hFF, 8'hFF);
        check_display(16'h0100, 8'hC0, 8'hC0, 8'hF9, 8'hFF);

        // 6: async reset in the middle of a prescaler period
        en = 1'b1;
        load_now(16'h0123);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'h0000);
        chk("async_tick", 32'(tick), 32'h0);
        chk("async_carry", 32'(carry), 32'h0);
        chk("async_an", 32'(an), 32'hE);
        chk("async_seg", 32'(seg), 32'hC0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
